// File: rtl/dsk_image_manager.sv
// Disk image manager: maps data_io download words onto per-slot SDRAM regions,
// classifies finished images, handles eject and owns the system reset hold.
// Optional per-slot data checksum output is built when IMG_CHECKSUM_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a rising dl_active
// LOAD   | download in progress, tracking the last written word address
// FINAL  | one cycle: classify the slot image / mark the ROM loaded
module dsk_image_manager #(
   parameter int SLOTS      = 2,
   parameter int ADDR_W     = 21,
   parameter int SLOT_SHIFT = 19,
   parameter int DS_WORDS   = 409600,
   parameter int SS_WORDS   = 204800,
   parameter int RST_HOLD   = 65535
) (
   input  logic              clk,
   input  logic              _systemReset,
   input  logic              clk_en,
   input  logic              dl_active,
   input  logic [4:0]        dl_index,
   input  logic [23:0]       dl_addr,
   input  logic              dl_wr,
   input  logic              bus_slot,
   input  logic [SLOTS-1:0]  eject,
   input  logic [1:0]        mem_cfg,
   input  logic              reset_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              download_cycle,
   output logic [SLOTS-1:0]  inserted,
   output logic [SLOTS-1:0]  double_sided,
   output logic [SLOTS-1:0]  overflow,
   output logic              sys_reset_n,
   output logic              rom_loaded
`ifdef IMG_CHECKSUM_EN
   ,
   input  logic [15:0]           dl_data,
   output logic [16*SLOTS+15:0]  checksum
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;
   localparam int         CNT_W   = $clog2(RST_HOLD + 1);
   localparam logic [4:0] SLOTS_IDX = 5'(SLOTS);

   logic [1:0]        state;
   logic [4:0]        idx;
   logic              dl_prev;
   logic [23:0]       last_addr;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        cfg_q;
   logic              idx_rom, idx_disk, addr_ok, wr_try, ovf_hit, start, reload;
   logic              ds_ok, ss_ok;
   logic [ADDR_W-1:0] slot_base, slot_off;

   assign download_cycle = dl_active && bus_slot;
   assign idx_rom  = (dl_index == 5'd0);
   assign idx_disk = !idx_rom && (dl_index <= SLOTS_IDX);
   assign addr_ok  = ((dl_addr >> SLOT_SHIFT) == 24'd0);
   assign wr_try   = dl_wr && download_cycle && (state == S_LOAD);
   assign mem_we   = wr_try && (idx_rom || (idx_disk && addr_ok));
   assign ovf_hit  = wr_try && idx_disk && !addr_ok;
   // dl_prev resets high so a download already running at reset release is ignored
   assign start    = (state == S_IDLE) && dl_active && !dl_prev;
   assign ds_ok    = (last_addr == 24'(DS_WORDS - 1));
   assign ss_ok    = (last_addr == 24'(SS_WORDS - 1));

   assign slot_base = ADDR_W'(dl_index) << SLOT_SHIFT;
   assign slot_off  = ADDR_W'(dl_addr[SLOT_SHIFT-1:0]);

   always_comb begin
      mem_addr = dl_addr[ADDR_W-1:0];
      if (idx_disk)
         mem_addr = slot_base + slot_off;
   end

   always_ff @(posedge clk or negedge _systemReset) begin
      if (!_systemReset) begin
         state        <= S_IDLE;
         idx          <= '0;
         dl_prev      <= 1'b1;
         last_addr    <= '0;
         inserted     <= '0;
         double_sided <= '0;
         overflow     <= '0;
         rom_loaded   <= 1'b0;
      end else begin
         dl_prev <= dl_active;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_LOAD;
                  idx       <= dl_index;
                  last_addr <= '0;
                  for (int j = 0; j < SLOTS; j++) begin
                     if (dl_index == 5'(j + 1)) begin
                        inserted[j]     <= 1'b0;
                        double_sided[j] <= 1'b0;
                        overflow[j]     <= 1'b0;
                     end
                  end
               end
            end
            S_LOAD: begin
               if (mem_we)
                  last_addr <= dl_addr;
               for (int j = 0; j < SLOTS; j++) begin
                  if (ovf_hit && dl_index == 5'(j + 1))
                     overflow[j] <= 1'b1;
               end
               if (!dl_active)
                  state <= S_FINAL;
            end
            S_FINAL: begin
               for (int j = 0; j < SLOTS; j++) begin
                  if (idx == 5'(j + 1)) begin
                     double_sided[j] <= ds_ok && !overflow[j];
                     inserted[j]     <= (ds_ok || ss_ok) && !overflow[j];
                  end
               end
               if (idx == 5'd0)
                  rom_loaded <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         // eject comes last so it wins over a coinciding FINAL
         for (int j = 0; j < SLOTS; j++) begin
            if (eject[j]) begin
               inserted[j]     <= 1'b0;
               double_sided[j] <= 1'b0;
            end
         end
      end
   end

   assign reload = reset_req || ((state == S_LOAD) && (idx == 5'd0)) ||
                   (mem_cfg != cfg_q) || !rom_loaded;

   always_ff @(posedge clk or negedge _systemReset) begin
      if (!_systemReset) begin
         cnt         <= CNT_W'(RST_HOLD);
         cfg_q       <= '0;
         sys_reset_n <= 1'b0;
      end else if (clk_en) begin
         cfg_q <= mem_cfg;
         if (reload)
            cnt <= CNT_W'(RST_HOLD);
         else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
         sys_reset_n <= (cnt == '0) && !reload;
      end
   end

`ifdef IMG_CHECKSUM_EN
   logic [15:0] sum;

   always_ff @(posedge clk or negedge _systemReset) begin
      if (!_systemReset) begin
         sum      <= '0;
         checksum <= '0;
      end else begin
         if (start)
            sum <= '0;
         else if (mem_we)
            sum <= sum + dl_data;
         if (state == S_FINAL) begin
            for (int j = 0; j <= SLOTS; j++) begin
               if (idx == 5'(j))
                  checksum[16*j +: 16] <= sum;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_dsk_image_manager.sv
// Directed bench for dsk_image_manager with a short reset hold.
module tb_dsk_image_manager;
   localparam int H = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clk_en = 1'b0;
   logic        dl_active = 1'b0;
   logic [4:0]  dl_index = '0;
   logic [23:0] dl_addr = '0;
   logic        dl_wr = 1'b0;
   logic        bus_slot = 1'b0;
   logic [1:0]  eject = '0;
   logic [1:0]  mem_cfg = 2'b10;
   logic        reset_req = 1'b0;
   logic [20:0] mem_addr;
   logic        mem_we, download_cycle, sys_reset_n, rom_loaded;
   logic [1:0]  inserted, double_sided, overflow;

   int checks = 0;
   int passes = 0;
   int n1, n2;
   bit got;
   logic [1:0] div = '0;

   dsk_image_manager #(.RST_HOLD(H)) dut (
      .clk(clk), ._systemReset(rst_n), .clk_en(clk_en), .dl_active(dl_active),
      .dl_index(dl_index), .dl_addr(dl_addr), .dl_wr(dl_wr), .bus_slot(bus_slot),
      .eject(eject), .mem_cfg(mem_cfg), .reset_req(reset_req), .mem_addr(mem_addr),
      .mem_we(mem_we), .download_cycle(download_cycle), .inserted(inserted),
      .double_sided(double_sided), .overflow(overflow), .sys_reset_n(sys_reset_n),
      .rom_loaded(rom_loaded)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      div = div + 2'd1;
      clk_en = (div == 2'd0);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic dl_begin(input logic [4:0] i);
      dl_index = i; dl_wr = 1'b0; bus_slot = 1'b0; dl_active = 1'b1;
      tick(2);
   endtask

   task automatic dl_end();
      dl_active = 1'b0;
      tick(3);
   endtask

   task automatic wr(input logic [23:0] a, input logic exp_we, input string tag);
      dl_addr = a; dl_wr = 1'b1; bus_slot = 1'b1;
      #1 chk(tag, 32'(mem_we), 32'(exp_we));
      @(negedge clk);
      dl_wr = 1'b0; bus_slot = 1'b0;
   endtask

   // counts clk_en ticks until sys_reset_n reaches lvl (bounded)
   task automatic count_ticks(input logic lvl, output int n_out);
      int n = 0;
      bit done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(posedge clk);
         if (clk_en) n++;
         @(negedge clk);
         if (sys_reset_n === lvl) done = 1;
      end
      n_out = n;
   endtask

   initial begin
      tick(3);
      chk("rst_inserted", 32'(inserted), 32'd0);
      chk("rst_double", 32'(double_sided), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_sysrst", 32'(sys_reset_n), 32'd0);
      chk("rst_rom", 32'(rom_loaded), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      rst_n = 1'b1;
      tick(3);

      // ROM download, bus_slot gating and address truncation
      dl_begin(5'd0);
      dl_addr = 24'hF23456; dl_wr = 1'b1; bus_slot = 1'b0;
      #1 chk("rom_we_noslot", 32'(mem_we), 32'd0);
      chk("rom_dlcycle_noslot", 32'(download_cycle), 32'd0);
      @(negedge clk); bus_slot = 1'b1;
      #1 chk("rom_we_slot", 32'(mem_we), 32'd1);
      chk("rom_addr_trunc", 32'(mem_addr), 32'h123456);
      @(negedge clk); dl_wr = 1'b0; bus_slot = 1'b0;
      wr(24'h00FFFF, 1'b1, "rom_we_last");
      dl_active = 1'b0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (rom_loaded) got = 1;
      end
      chk("rom_loaded", 32'(rom_loaded), 32'd1);
      chk("rom_sysrst_held", 32'(sys_reset_n), 32'd0);
      count_ticks(1'b1, n1);
      chk("rom_hold_ticks", 32'(n1), 32'(H + 1));

      // slot 1 double-sided image
      dl_begin(5'd1);
      wr(24'd0, 1'b1, "s1_we0");
      dl_addr = 24'd409599; dl_wr = 1'b1; bus_slot = 1'b1;
      #1 chk("s1_addr_last", 32'(mem_addr), 32'h0E3FFF);
      chk("s1_we_last", 32'(mem_we), 32'd1);
      @(negedge clk); dl_wr = 1'b0; bus_slot = 1'b0;
      chk("s1_ins_loading", 32'(inserted), 32'd0);
      dl_end();
      chk("s1_inserted", 32'(inserted), 32'b01);
      chk("s1_double", 32'(double_sided), 32'b01);

      // slot 2 single-sided image
      dl_begin(5'd2);
      dl_addr = 24'd204799; dl_wr = 1'b1; bus_slot = 1'b1;
      #1 chk("s2_addr_last", 32'(mem_addr), 32'h131FFF);
      @(negedge clk); dl_wr = 1'b0; bus_slot = 1'b0;
      dl_end();
      chk("s2_inserted", 32'(inserted), 32'b11);
      chk("s2_double", 32'(double_sided), 32'b01);

      // index beyond SLOTS leaves everything alone
      dl_begin(5'd7);
      wr(24'h000010, 1'b0, "idx7_we");
      dl_end();
      chk("idx7_inserted", 32'(inserted), 32'b11);
      chk("idx7_double", 32'(double_sided), 32'b01);
      chk("idx7_overflow", 32'(overflow), 32'd0);

      // slot 2 aborted download
      dl_begin(5'd2);
      chk("s2abort_cleared", 32'(inserted), 32'b01);
      wr(24'd1000, 1'b1, "s2abort_we");
      dl_end();
      chk("s2abort_inserted", 32'(inserted), 32'b01);

      // eject of empty slot, then of slot 1
      eject = 2'b10; tick(1); eject = 2'b00; tick(1);
      chk("eject_empty", 32'(inserted), 32'b01);
      eject = 2'b01; tick(1); eject = 2'b00; tick(1);
      chk("eject_s1_ins", 32'(inserted), 32'b00);
      chk("eject_s1_ds", 32'(double_sided), 32'b00);

      // slot 1 overflow
      dl_begin(5'd1);
      wr(24'd409599, 1'b1, "ovf_we_ok");
      dl_addr = 24'h080000; dl_wr = 1'b1; bus_slot = 1'b1;
      #1 chk("ovf_we_blocked", 32'(mem_we), 32'd0);
      chk("ovf_addr", 32'(mem_addr), 32'h080000);
      @(negedge clk); dl_wr = 1'b0; bus_slot = 1'b0;
      chk("ovf_flag_live", 32'(overflow), 32'b01);
      dl_end();
      chk("ovf_overflow", 32'(overflow), 32'b01);
      chk("ovf_inserted", 32'(inserted), 32'b00);

      // eject coinciding with FINAL
      dl_begin(5'd1);
      chk("fin_ovf_cleared", 32'(overflow), 32'b00);
      wr(24'd409599, 1'b1, "fin_we");
      dl_active = 1'b0;
      @(negedge clk); eject = 2'b01;
      @(negedge clk); eject = 2'b00;
      tick(1);
      chk("fin_eject_ins", 32'(inserted), 32'b00);
      chk("fin_eject_ds", 32'(double_sided), 32'b00);

      // mem_cfg change restarts the full hold
      chk("cfg_sysrst_before", 32'(sys_reset_n), 32'd1);
      mem_cfg = 2'b11;
      count_ticks(1'b0, n1);
      chk("cfg_drop_ticks", 32'(n1), 32'd1);
      count_ticks(1'b1, n2);
      chk("cfg_hold_ticks", 32'(n1 + n2), 32'(H + 2));

      // asynchronous reset in the middle of a slot 1 load
      dl_begin(5'd1);
      wr(24'd5, 1'b1, "ar_we_before");
      rst_n = 1'b0;
      #1;
      chk("ar_rom", 32'(rom_loaded), 32'd0);
      chk("ar_sysrst", 32'(sys_reset_n), 32'd0);
      chk("ar_inserted", 32'(inserted), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      wr(24'd409599, 1'b0, "ar_ignored_we");
      dl_end();
      chk("ar_after_ins", 32'(inserted), 32'd0);
      dl_begin(5'd1);
      wr(24'd204799, 1'b1, "ar_fresh_we");
      dl_end();
      chk("ar_fresh_ins", 32'(inserted), 32'b01);
      chk("ar_fresh_ds", 32'(double_sided), 32'b00);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
